// File: rtl/vpu_pkg.sv
// Shared types and constants for the video path: FSM states, 640x480 timing,
// framebuffer geometry and the RGB444 colour type.
package vpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DRAW  = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef logic [11:0] color_t;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam int FB_W    = 160;
    localparam int FB_H    = 120;
    localparam int FB_SIZE = FB_W * FB_H;
    localparam int FB_AW   = 15;

    // Linear framebuffer word address of a (column, row) pair
    function automatic logic [FB_AW-1:0] fb_index(input logic [9:0] col,
                                                  input logic [9:0] row);
        return FB_AW'(32'(row) * FB_W + 32'(col));
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing: divides clkin by 4 into the pixel rate and walks
// the 800x525 raster, producing undelayed sync/blank for the pixel pipeline.
module vga_timing_gen import vpu_pkg::*; (
    input  logic       clkin,
    input  logic       rst,
    output logic       pix_en,
    output logic       pix_clk,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       hsync_raw,
    output logic       vsync_raw,
    output logic       blank_raw
);

    logic [1:0] div;

    // Free-running divide-by-4; its MSB is the 25 MHz pixel clock
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            div <= 2'd0;
        end else begin
            div <= div + 2'd1;
        end
    end

    assign pix_en  = (div == 2'd3);
    assign pix_clk = div[1];

    // Raster position, advancing one pixel per pix_en and one line per h wrap
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            h_cnt <= 10'd0;
            v_cnt <= 10'd0;
        end else if (pix_en) begin
            if (h_cnt == 10'(H_TOTAL - 1)) begin
                h_cnt <= 10'd0;
                if (v_cnt == 10'(V_TOTAL - 1)) begin
                    v_cnt <= 10'd0;
                end else begin
                    v_cnt <= v_cnt + 10'd1;
                end
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    assign hsync_raw = !((h_cnt >= 10'(H_VISIBLE + H_FRONT)) &&
                         (h_cnt <  10'(H_VISIBLE + H_FRONT + H_SYNC)));
    assign vsync_raw = !((v_cnt >= 10'(V_VISIBLE + V_FRONT)) &&
                         (v_cnt <  10'(V_VISIBLE + V_FRONT + V_SYNC)));
    assign blank_raw = (h_cnt < 10'(H_VISIBLE)) && (v_cnt < 10'(V_VISIBLE));

endmodule

// File: rtl/cpu_vpu_sys_top.sv
// Video path top: refresh tick, framebuffer line-drawing FSM, 160x120 RGB444
// framebuffer and a 2-stage pixel pipeline feeding the DVI transmitter.
module cpu_vpu_sys_top import vpu_pkg::*; #(
    parameter int     REFRESH_MAX = 1666667,
    parameter color_t BG_COLOR    = 12'h000,
    parameter color_t LINE_COLOR  = 12'hFFF
) (
    input  logic        clkin,
    input  logic        rst,
    output logic        hsync,
    output logic        vsync,
    output logic        blank,
    output logic [11:0] D,
    output logic        dvi_rst,
    output logic        clk_25mhz,
    output logic        clk_25mhz_n,
    inout  wire         scl_tri,
    inout  wire         sda_tri
);

    localparam int RW = $clog2(REFRESH_MAX + 1);

    logic             pix_en;
    logic             pix_clk;
    logic [9:0]       h_cnt;
    logic [9:0]       v_cnt;
    logic             hsync_raw;
    logic             vsync_raw;
    logic             blank_raw;

    logic [RW-1:0]    refresh_cnt;
    logic             frame_tick;

    state_t           state;
    state_t           nxt_state;
    logic [FB_AW-1:0] addr;
    logic [6:0]       line_i;
    logic [FB_AW-1:0] draw_addr;

    logic             fb_we;
    logic [FB_AW-1:0] fb_waddr;
    color_t           fb_wdata;
    logic [FB_AW-1:0] fb_raddr;
    color_t           fb_rdata;
    color_t           fb_mem [FB_SIZE];

    logic             hsync_d1;
    logic             vsync_d1;
    logic             blank_d1;

    vga_timing_gen u_timing (
        .clkin     (clkin),
        .rst       (rst),
        .pix_en    (pix_en),
        .pix_clk   (pix_clk),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .hsync_raw (hsync_raw),
        .vsync_raw (vsync_raw),
        .blank_raw (blank_raw)
    );

    assign clk_25mhz   = pix_clk;
    assign clk_25mhz_n = ~pix_clk;

    assign scl_tri = 1'bz;
    assign sda_tri = 1'bz;

    // Hold the DVI chip in reset until one clock after our own reset lifts
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            dvi_rst <= 1'b0;
        end else begin
            dvi_rst <= 1'b1;
        end
    end

    // Refresh divider: one frame_tick every REFRESH_MAX+1 clocks
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            refresh_cnt <= '0;
        end else if (frame_tick) begin
            refresh_cnt <= '0;
        end else begin
            refresh_cnt <= refresh_cnt + RW'(1);
        end
    end

    assign frame_tick = (refresh_cnt == RW'(REFRESH_MAX));

    // Line generator state register
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nxt_state;
        end
    end

    // Next state and framebuffer write port; ticks outside IDLE are ignored
    always_comb begin
        nxt_state = state;
        fb_we     = 1'b0;
        fb_waddr  = addr;
        fb_wdata  = BG_COLOR;
        case (state)
            IDLE: begin
                if (frame_tick) begin
                    nxt_state = CLEAR;
                end
            end
            CLEAR: begin
                fb_we = 1'b1;
                if (addr == FB_AW'(FB_SIZE - 1)) begin
                    nxt_state = DRAW;
                end
            end
            DRAW: begin
                fb_we    = 1'b1;
                fb_waddr = draw_addr;
                fb_wdata = LINE_COLOR;
                if (line_i == 7'(FB_H - 1)) begin
                    nxt_state = DONE;
                end
            end
            DONE: begin
                nxt_state = IDLE;
            end
            default: begin
                nxt_state = IDLE;
            end
        endcase
    end

    // Clear address and diagonal step; draw_addr tracks line_i*(FB_W+1) without a multiplier
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            addr      <= '0;
            line_i    <= 7'd0;
            draw_addr <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    addr      <= addr + FB_AW'(1);
                    line_i    <= 7'd0;
                    draw_addr <= '0;
                end
                DRAW: begin
                    addr      <= '0;
                    line_i    <= line_i + 7'd1;
                    draw_addr <= draw_addr + FB_AW'(FB_W + 1);
                end
                default: begin
                    addr      <= '0;
                    line_i    <= 7'd0;
                    draw_addr <= '0;
                end
            endcase
        end
    end

    // Each framebuffer pixel covers a 4x4 block of screen pixels; off-screen reads park at 0
    assign fb_raddr = blank_raw ? fb_index(h_cnt >> 2, v_cnt >> 2) : '0;

    // Dual-port framebuffer, contents deliberately not reset; read-during-write gives old data
    always_ff @(posedge clkin) begin
        if (fb_we) begin
            fb_mem[fb_waddr] <= fb_wdata;
        end
        if (pix_en) begin
            fb_rdata <= fb_mem[fb_raddr];
        end
    end

    // Delay sync/blank through two stages so they line up with the read data
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            hsync_d1 <= 1'b1;
            vsync_d1 <= 1'b1;
            blank_d1 <= 1'b0;
            hsync    <= 1'b1;
            vsync    <= 1'b1;
            blank    <= 1'b0;
            D        <= 12'h000;
        end else if (pix_en) begin
            hsync_d1 <= hsync_raw;
            vsync_d1 <= vsync_raw;
            blank_d1 <= blank_raw;
            hsync    <= hsync_d1;
            vsync    <= vsync_d1;
            blank    <= blank_d1;
            D        <= blank_d1 ? fb_rdata : 12'h000;
        end
    end

endmodule

// File: tb/tb_cpu_vpu_sys_top.sv
// Self-checking bench for cpu_vpu_sys_top: reset, pixel clock, frame draw,
// forced draw, scanned pixel stream and reset during clear.
module tb_cpu_vpu_sys_top;
    import vpu_pkg::*;

    logic        clkin = 1'b0;
    logic        rst   = 1'b0;
    logic        hsync;
    logic        vsync;
    logic        blank;
    logic [11:0] D;
    logic        dvi_rst;
    logic        clk_25mhz;
    logic        clk_25mhz_n;
    wire         scl_tri;
    wire         sda_tri;

    int n_checks = 0;
    int n_fail   = 0;

    cpu_vpu_sys_top dut (
        .clkin       (clkin),
        .rst         (rst),
        .hsync       (hsync),
        .vsync       (vsync),
        .blank       (blank),
        .D           (D),
        .dvi_rst     (dvi_rst),
        .clk_25mhz   (clk_25mhz),
        .clk_25mhz_n (clk_25mhz_n),
        .scl_tri     (scl_tri),
        .sda_tri     (sda_tri)
    );

    // 100 MHz board clock
    always #5 clkin = ~clkin;

    // Expected {hsync, vsync, blank, D} for raster position (h, v) after one clear+draw
    function automatic logic [14:0] exp_pix(input int h, input int v);
        logic        hs;
        logic        vs;
        logic        bl;
        logic [11:0] d;
        hs = !(h >= 656 && h < 752);
        vs = !(v >= 490 && v < 492);
        bl = (h < 640) && (v < 480);
        d  = (bl && (v / 4) == (h / 4) && (v / 4) < 120) ? 12'hFFF : 12'h000;
        return {hs, vs, bl, d};
    endfunction

    task automatic fire_tick();
        @(negedge clkin);
        force dut.refresh_cnt = 21'd1666667;
        @(negedge clkin);
        release dut.refresh_cnt;
    endtask

    task automatic test_reset();
        logic exp_clk;
        @(negedge clkin);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({hsync, vsync, blank, D} !== {1'b1, 1'b1, 1'b0, 12'h000}) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got %h expected %h", {hsync, vsync, blank, D}, {1'b1, 1'b1, 1'b0, 12'h000});
        end
        n_checks++;
        if ({dvi_rst, clk_25mhz} !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL reset_dvi_clk: got %b expected 00", {dvi_rst, clk_25mhz});
        end
        n_checks++;
        if (dut.state !== IDLE) begin
            n_fail++;
            $display("[TB] FAIL reset_state: got %0d expected %0d", dut.state, IDLE);
        end
        @(negedge clkin);
        rst = 1'b0;
        #1;
        n_checks++;
        if (dvi_rst !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL dvi_rst_early: got %b expected 0", dvi_rst);
        end
        for (int k = 1; k <= 8; k++) begin
            @(posedge clkin);
            #1;
            exp_clk = ((k % 4) >= 2);
            n_checks++;
            if (dvi_rst !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL dvi_rst_release cycle %0d: got %b expected 1", k, dvi_rst);
            end
            n_checks++;
            if ({clk_25mhz, clk_25mhz_n} !== {exp_clk, ~exp_clk}) begin
                n_fail++;
                $display("[TB] FAIL pix_clk cycle %0d: got %b expected %b", k, {clk_25mhz, clk_25mhz_n}, {exp_clk, ~exp_clk});
            end
        end
        $display("[TB] i2c lines released: scl=%b sda=%b", scl_tri, sda_tri);
    endtask

    task automatic test_frame_draw();
        int cnt;
        fire_tick();
        n_checks++;
        if (dut.state !== CLEAR || dut.addr !== 15'd0) begin
            n_fail++;
            $display("[TB] FAIL tick_to_clear: got state %0d addr %0d expected 1 0", dut.state, dut.addr);
        end
        cnt = 0;
        while (dut.state == CLEAR && cnt < 30000) begin
            cnt++;
            @(negedge clkin);
        end
        n_checks++;
        if (cnt != 19200 || dut.state !== DRAW) begin
            n_fail++;
            $display("[TB] FAIL clear_length: got %0d cycles state %0d expected 19200 state 2", cnt, dut.state);
        end
        cnt = 0;
        while (dut.state == DRAW && cnt < 1000) begin
            cnt++;
            @(negedge clkin);
        end
        n_checks++;
        if (cnt != 120 || dut.state !== DONE) begin
            n_fail++;
            $display("[TB] FAIL draw_length: got %0d cycles state %0d expected 120 state 3", cnt, dut.state);
        end
        @(negedge clkin);
        n_checks++;
        if (dut.state !== IDLE) begin
            n_fail++;
            $display("[TB] FAIL done_to_idle: got %0d expected 0", dut.state);
        end
        n_checks++;
        if ({dut.fb_mem[0], dut.fb_mem[1], dut.fb_mem[161], dut.fb_mem[19159], dut.fb_mem[19199]}
                !== {12'hFFF, 12'h000, 12'hFFF, 12'hFFF, 12'h000}) begin
            n_fail++;
            $display("[TB] FAIL fb_contents: got %h %h %h %h %h expected fff 000 fff fff 000",
                     dut.fb_mem[0], dut.fb_mem[1], dut.fb_mem[161], dut.fb_mem[19159], dut.fb_mem[19199]);
        end
    endtask

    task automatic test_forced_draw();
        int exp_q[$];
        int writes;
        int e;
        for (int i = 0; i < 120; i++) begin
            exp_q.push_back(i * 161);
        end
        @(negedge clkin);
        n_checks++;
        if (dut.state !== IDLE) begin
            n_fail++;
            $display("[TB] FAIL forced_draw_pre: got %0d expected 0", dut.state);
        end
        force dut.nxt_state = DRAW;
        @(negedge clkin);
        release dut.nxt_state;
        writes = 0;
        while (dut.state == DRAW && writes < 1000) begin
            if (dut.fb_we) begin
                writes++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL forced_write_extra: got addr %0d expected no write", dut.fb_waddr);
                end else begin
                    e = exp_q.pop_front();
                    n_checks++;
                    if (int'(dut.fb_waddr) != e || dut.fb_wdata !== 12'hFFF) begin
                        n_fail++;
                        $display("[TB] FAIL forced_write: got addr %0d data %h expected addr %0d data fff",
                                 dut.fb_waddr, dut.fb_wdata, e);
                    end
                end
            end
            @(negedge clkin);
        end
        n_checks++;
        if (writes != 120 || exp_q.size() != 0 || dut.state !== DONE) begin
            n_fail++;
            $display("[TB] FAIL forced_draw_count: got %0d writes state %0d expected 120 writes state 3", writes, dut.state);
        end
        @(negedge clkin);
        n_checks++;
        if (dut.state !== IDLE) begin
            n_fail++;
            $display("[TB] FAIL forced_draw_idle: got %0d expected 0", dut.state);
        end
    endtask

    task automatic test_scan_lines();
        logic [14:0] sb_q[$];
        logic [14:0] e;
        int mdiv;
        int mh;
        int mv;
        int outs;
        int hs_low;
        int bl_hi;
        mdiv   = 0;
        mh     = 0;
        mv     = 0;
        outs   = 0;
        hs_low = 0;
        bl_hi  = 0;
        @(negedge clkin);
        rst = 1'b1;
        @(negedge clkin);
        rst = 1'b0;
        for (int c = 0; c < 6 * 800 * 4 + 8; c++) begin
            @(posedge clkin);
            #1;
            if (mdiv == 3) begin
                sb_q.push_back(exp_pix(mh, mv));
                if (sb_q.size() == 2) begin
                    e = sb_q.pop_front();
                    n_checks++;
                    if ({hsync, vsync, blank, D} !== e) begin
                        n_fail++;
                        $display("[TB] FAIL pixel out %0d: got %h expected %h", outs, {hsync, vsync, blank, D}, e);
                    end
                    outs++;
                    if (!hsync) hs_low++;
                    if (blank) bl_hi++;
                    if (outs % 800 == 0 && outs <= 1600) begin
                        n_checks++;
                        if (hs_low != 96 || bl_hi != 640) begin
                            n_fail++;
                            $display("[TB] FAIL line_timing %0d: got hsync_low %0d blank_high %0d expected 96 640",
                                     outs / 800, hs_low, bl_hi);
                        end
                        hs_low = 0;
                        bl_hi  = 0;
                    end
                end
                if (mh == 799) begin
                    mh = 0;
                    mv = (mv == 524) ? 0 : mv + 1;
                end else begin
                    mh++;
                end
            end
            mdiv = (mdiv + 1) % 4;
        end
    endtask

    task automatic test_reset_mid_clear();
        fire_tick();
        repeat (50) @(negedge clkin);
        n_checks++;
        if (dut.state !== CLEAR || dut.addr !== 15'd50) begin
            n_fail++;
            $display("[TB] FAIL mid_clear_pre: got state %0d addr %0d expected 1 50", dut.state, dut.addr);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (dut.state !== IDLE || dut.addr !== 15'd0) begin
            n_fail++;
            $display("[TB] FAIL mid_clear_abort: got state %0d addr %0d expected 0 0", dut.state, dut.addr);
        end
        @(negedge clkin);
        rst = 1'b0;
        @(negedge clkin);
        n_checks++;
        if (dut.fb_mem[0] !== 12'h000 || dut.fb_mem[161] !== 12'hFFF) begin
            n_fail++;
            $display("[TB] FAIL partial_clear: got %h %h expected 000 fff", dut.fb_mem[0], dut.fb_mem[161]);
        end
        fire_tick();
        n_checks++;
        if (dut.state !== CLEAR || dut.fb_we !== 1'b1 || dut.fb_waddr !== 15'd0) begin
            n_fail++;
            $display("[TB] FAIL restart_clear: got state %0d we %b addr %0d expected 1 1 0",
                     dut.state, dut.fb_we, dut.fb_waddr);
        end
        @(negedge clkin);
        n_checks++;
        if (dut.addr !== 15'd1) begin
            n_fail++;
            $display("[TB] FAIL restart_step: got %0d expected 1", dut.addr);
        end
    endtask

    initial begin
        test_reset();
        test_frame_draw();
        test_forced_draw();
        test_scan_lines();
        test_reset_mid_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
